flex_lane_downsizer: RTL
========================

// Module: flex_lane_downsizer
// PURPOSE
// - Parametrised wide-to-narrow AXI-Stream downsizer for the data-route fabric.
// - Holds one IN_W word and emits OUT_W beats from a lane window that advances by a programmable step.
// - Replicates each window lane per the configured replication mode.
// - Sits between the wide on-chip buffer read port and the systolic-array feed lanes.
// - Adds over the fixed 1536->256 converter: generic widths, lane-granular step, clean replication modes,
//   TLAST propagation, zero-bubble reload and AXI-compliant stall behaviour.
// PARAMETERS
// - IN_W    1536  input word width (bits); multiple of LANE_W
// - OUT_W   256   output beat width (bits); multiple of LANE_W; OUT_W <= IN_W
// - LANE_W  64    lane granularity (bits)
// - Derived: NI = IN_W/LANE_W (24); NO = OUT_W/LANE_W (4); CW = $clog2(NI+1)
// PORTS
// - clk            in   1           clock
// - rst            in   1           synchronous reset, active-high
// - cfg_step       in   CW          lanes the window advances per output beat
// - cfg_rep_log2   in   $clog2(NO)+1  distinct lanes per beat R = 2**cfg_rep_log2
// - s_axis_tdata   in   IN_W        input word; lane k = bits [k*LANE_W +: LANE_W]
// - s_axis_tlast   in   1           end of packet marker for input word
// - s_axis_tvalid  in   1           input valid
// - s_axis_tready  out  1           input ready
// - m_axis_tdata   out  OUT_W       output beat
// - m_axis_tlast   out  1           last beat of a TLAST input word
// - m_axis_tvalid  out  1           output valid
// - m_axis_tready  in   1           output ready
// BEHAVIOUR
// - Reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, held word=0, offset=0, state EMPTY.
// - Reset: s_axis_tready=1 from first cycle after reset deasserts.
// - States:
//   - EMPTY: no word held.
//   - DRAIN: a word is held with offset off (lanes).
// - Config is sampled only on EMPTY->DRAIN load; changes during DRAIN have no effect.
// - Config clamps: step 0 -> 1, step > NI -> NI; cfg_rep_log2 > log2(NO) -> log2(NO).
// - Beat content at offset off: output lane i = held lane (off + (i mod R)).
//   - Held lanes >= NI read as 0 (zero pad).
// - Beats per word = ceil(NI/step); last beat is the one where off+step >= NI.
// - m_axis_tlast = 1 only on last beat of a word loaded with s_axis_tlast=1.
// - s_axis_tready = (state==EMPTY) | (m_axis_tvalid & m_axis_tready & last beat).
//   - Combinational from registered state plus m_axis_tready.
// - Load on s_axis_tvalid & s_axis_tready:
//   - word captured; off=0; first beat valid next cycle (latency 1).
//   - From DRAIN last beat: zero-bubble, next word's beat 0 follows immediately.
// - Advance on m_axis_tvalid & m_axis_tready, not last beat: off += step.
// - Last beat accepted with no input valid -> EMPTY, m_axis_tvalid=0 next cycle.
// - Stall: m_axis_tvalid=1 & m_axis_tready=0 -> tdata/tlast/off held stable; s_axis_tready=0.
// - Simultaneous last-beat accept and input valid: load wins, no gap cycle, no dropped word.
// - rst mid-DRAIN: held word discarded, outputs return to reset values next cycle.
// - Offset arithmetic uses CW+1 bits, no wrap.
// CONFIGURATION
// - Macro FLD_PERF_CNT_EN defined: adds outputs perf_in_words, perf_out_beats, perf_stall_cyc (32b each).
//   - Counts accepted inputs, accepted outputs and cycles with tvalid&!tready.
//   - Counters saturate at 2**32-1 and clear on rst.
// - Macro not defined: ports and counters absent; datapath behaviour identical.
// TESTING
// - Defaults; input lane k = k; rep_log2=2, step=4; ready=1.
//   -> 6 beats, beat j lanes {4j..4j+3}; tlast on beat 6 only.
// - rep_log2=0, step=1.
//   -> 24 beats, beat j = lane j replicated 4x.
// - rep_log2=1, step=2.
//   -> beat j = {2j, 2j+1, 2j, 2j+1} (lane0..3).
// - rep_log2=2, step=3.
//   -> 8 beats at offsets 0,3,..,21; last beat = {21,22,23,0}.
// - Two back-to-back words, step=2, ready=1.
//   -> 24 beats in 24 consecutive cycles; s_axis_tready high only on beats 12 and 24.
// - Random m_axis_tready stalls and mid-drain config changes.
//   -> tdata stable while stalled; sequence matches model; config change takes effect next word.
//   - Also: rst asserted at beat 3 -> tvalid=0 next cycle, new word restarts at off=0.

Source files
------------

// File: rtl/flex_lane_downsizer_if.sv
`default_nettype none
// ============================================================================
// Module   : flex_lane_downsizer_if
// Purpose  : AXI-Stream style bundle (tdata/tlast/tvalid/tready) with
//            master and slave views, used for both sides of the downsizer.
// Revision : 1.0
// ============================================================================
interface flex_lane_downsizer_if #(
   parameter int DATA_W = 256
) ();
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/flex_lane_downsizer.sv
`default_nettype none
// ============================================================================
// Module   : flex_lane_downsizer
// Purpose  : Wide-to-narrow AXI-Stream downsizer; emits OUT_W beats from a
//            lane window stepping across a held IN_W word, with lane
//            replication. Optional macro FLD_PERF_CNT_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module flex_lane_downsizer #(
   parameter  int IN_W   = 1536,
   parameter  int OUT_W  = 256,
   parameter  int LANE_W = 64,
   localparam int NI     = IN_W / LANE_W,
   localparam int NO     = OUT_W / LANE_W,
   localparam int CW     = $clog2(NI + 1),
   localparam int RW     = $clog2(NO) + 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [CW-1:0]    cfg_step,
   input  wire logic [RW-1:0]    cfg_rep_log2,
   flex_lane_downsizer_if.slave  s_axis,
   flex_lane_downsizer_if.master m_axis
`ifdef FLD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_in_words,
   output logic [31:0]           perf_out_beats,
   output logic [31:0]           perf_stall_cyc
`endif
);

   localparam int NOL2 = $clog2(NO);
   localparam int OW   = CW + 1;
   localparam int NPAD = 2 ** OW;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IN_W-1:0]   word_q, word_d;
   logic [OW-1:0]     off_q, off_d;
   logic [CW-1:0]     step_q, step_d;
   logic [RW-1:0]     rep_q, rep_d;
   logic              wlast_q, wlast_d;
   logic [OUT_W-1:0]  tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;

   logic [CW-1:0]     w_step_c;
   logic [RW-1:0]     w_rep_c;
   logic              w_out_acc, w_last_beat, w_s_ready, w_load, w_adv;
   logic [IN_W-1:0]   w_src_word;
   logic [OW-1:0]     w_src_off;
   logic [CW-1:0]     w_src_step;
   logic [RW-1:0]     w_src_rep;
   logic              w_src_wlast;
   logic [OW-1:0]     w_rep_mask;
   logic [OUT_W-1:0]  w_beat;
   logic [LANE_W-1:0] w_lanes [NPAD];

   always_comb begin
      w_step_c = cfg_step;
      if (cfg_step == '0) begin
         w_step_c = CW'(1);
      end else if (cfg_step > CW'(NI)) begin
         w_step_c = CW'(NI);
      end
      w_rep_c = cfg_rep_log2;
      if (cfg_rep_log2 > RW'(NOL2)) begin
         w_rep_c = RW'(NOL2);
      end
   end

   assign w_out_acc   = tvalid_q & m_axis.tready;
   assign w_last_beat = (off_q + OW'(step_q)) >= OW'(NI);
   assign w_s_ready   = (state_q == ST_EMPTY) | (w_out_acc & w_last_beat);
   assign w_load      = s_axis.tvalid & w_s_ready;
   assign w_adv       = w_out_acc & ~w_last_beat;

   // The next beat is built either from the incoming word (load) or from the
   // held word at the advanced offset, so one lane selector serves both.
   assign w_src_word  = w_load ? s_axis.tdata : word_q;
   assign w_src_off   = w_load ? '0 : (off_q + OW'(step_q));
   assign w_src_step  = w_load ? w_step_c : step_q;
   assign w_src_rep   = w_load ? w_rep_c : rep_q;
   assign w_src_wlast = w_load ? s_axis.tlast : wlast_q;
   assign w_rep_mask  = (OW'(1) << w_src_rep) - OW'(1);

   for (genvar k = 0; k < NPAD; k++) begin : g_pad
      if (k < NI) begin : g_live
         assign w_lanes[k] = w_src_word[k*LANE_W +: LANE_W];
      end else begin : g_zero
         assign w_lanes[k] = '0;
      end
   end

   for (genvar i = 0; i < NO; i++) begin : g_lane
      logic [OW-1:0] w_idx;
      assign w_idx = w_src_off + (OW'(i) & w_rep_mask);
      assign w_beat[i*LANE_W +: LANE_W] = w_lanes[w_idx];
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      off_d    = off_q;
      step_d   = step_q;
      rep_d    = rep_q;
      wlast_d  = wlast_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (w_load) begin
         state_d = ST_DRAIN;
         word_d  = s_axis.tdata;
         off_d   = '0;
         step_d  = w_step_c;
         rep_d   = w_rep_c;
         wlast_d = s_axis.tlast;
      end else if (w_adv) begin
         off_d = w_src_off;
      end else if (w_out_acc) begin
         state_d = ST_EMPTY;
      end
      if (w_load | w_adv) begin
         tvalid_d = 1'b1;
         tdata_d  = w_beat;
         tlast_d  = w_src_wlast & ((w_src_off + OW'(w_src_step)) >= OW'(NI));
      end else if (w_out_acc) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         word_q   <= '0;
         off_q    <= '0;
         step_q   <= CW'(1);
         rep_q    <= '0;
         wlast_q  <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         off_q    <= off_d;
         step_q   <= step_d;
         rep_q    <= rep_d;
         wlast_q  <= wlast_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign s_axis.tready = w_s_ready;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;

`ifdef FLD_PERF_CNT_EN
   logic [31:0] perf_in_q, perf_out_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_in_q    <= '0;
         perf_out_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (w_load && (perf_in_q != '1)) begin
            perf_in_q <= perf_in_q + 32'd1;
         end
         if (w_out_acc && (perf_out_q != '1)) begin
            perf_out_q <= perf_out_q + 32'd1;
         end
         if (tvalid_q && !m_axis.tready && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_in_words  = perf_in_q;
   assign perf_out_beats = perf_out_q;
   assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
`default_nettype wire
